exec_stage: RTL and testbench

Execute stage of the pipelined scalar/vector processor, between decode/register-read and memory. Selects forwarded or register operands, runs a lane-parallel ALU (M lanes of N bits, or scalar on lane 0), derives zero/negative flags, and captures results plus pass-through control bits into one packed EX/MEM pipeline register `bufferOut`.

---
 rtl/exec_if.sv | 33 +++
 rtl/exec_stage.sv | 95 +++++++++
 tb/tb_exec_stage.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_if.sv
// EX-stage bundle: operands, forwarding, control inputs and the packed EX/MEM register output.
interface exec_if #(
  parameter int N = 24,
  parameter int M = 6
);
  localparam int BW = 17 + 2 * N * M;

  logic           en;
  logic [N-1:0]   rd1, rd2, rd3, pc, imm;
  logic [N*M-1:0] rdv1, rdv2, rdv3;
  logic [N*M-1:0] Forward1, Forward2, Forward3;
  logic           Fa, Fb, Fc;
  logic [3:0]     aluControl, Rc, opCode;
  logic           immSrc, branchFlag, memWrite, memToReg, regWrite, modeSel;
  logic [1:0]     opType;
  logic [BW-1:0]  bufferOut;

  modport master (
    output en, rd1, rd2, rd3, pc, imm, rdv1, rdv2, rdv3,
    output Forward1, Forward2, Forward3, Fa, Fb, Fc,
    output aluControl, Rc, opCode, immSrc, branchFlag, memWrite, memToReg,
    output regWrite, modeSel, opType,
    input  bufferOut
  );

  modport slave (
    input  en, rd1, rd2, rd3, pc, imm, rdv1, rdv2, rdv3,
    input  Forward1, Forward2, Forward3, Fa, Fb, Fc,
    input  aluControl, Rc, opCode, immSrc, branchFlag, memWrite, memToReg,
    input  regWrite, modeSel, opType,
    output bufferOut
  );
endinterface

// File: rtl/exec_stage.sv
// Execute stage: operand/forward select, M-lane ALU, flags, one EX/MEM register.
// Define EXEC_MUL_EN to build the per-lane N x N multipliers for aluControl 0111.
module exec_stage #(
  parameter int N = 24,
  parameter int M = 6
) (
  input  logic  clk,
  input  logic  rst,
  exec_if.slave bus
);
  localparam int NM = N * M;
  localparam int BW = 17 + 2 * NM;

  function automatic logic signed [N-1:0] aluLane(input logic [3:0] op,
                                                  input logic [N-1:0] a,
                                                  input logic [N-1:0] b);
    logic signed [N-1:0] r;
    logic [4:0] sh;
    sh = b[4:0];
    r  = '0;
    case (op)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = (int'(sh) >= N) ? '0 : (a << sh);
      4'b0110: r = (int'(sh) >= N) ? '0 : (a >> sh);
`ifdef EXEC_MUL_EN
      4'b0111: r = a * b;
`endif
      4'b1000: r = b;
      4'b1001: r = a;
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [NM-1:0]       opA, opB, opThird, aluResult;
  logic [N-1:0]        cmpB;
  logic signed [N-1:0] cmpDiff;
  logic                isCtrl, zeroFlag, negFlag;
  logic [BW-1:0]       nextBuffer, bufferOut_p1;

  assign isCtrl = (bus.opType == 2'b10);

  // Scalar mode keeps everything in lane 0; upper lanes stay zero.
  always_comb begin
    opA     = '0;
    opB     = '0;
    opThird = '0;
    if (bus.modeSel) begin
      opA     = bus.Fa ? bus.Forward1 : bus.rdv1;
      opB     = bus.immSrc ? {M{bus.imm}} : (bus.Fb ? bus.Forward2 : bus.rdv2);
      opThird = bus.Fc ? bus.Forward3 : bus.rdv3;
    end else begin
      opA[N-1:0]     = bus.Fa ? bus.Forward1[N-1:0] : bus.rd1;
      opB[N-1:0]     = bus.immSrc ? bus.imm : (bus.Fb ? bus.Forward2[N-1:0] : bus.rd2);
      opThird[N-1:0] = bus.Fc ? bus.Forward3[N-1:0] : bus.rd3;
    end
  end

  // Branch compare sees the register/forwarded B even when immSrc selects the immediate.
  assign cmpB    = bus.Fb ? bus.Forward2[N-1:0] : (bus.modeSel ? bus.rdv2[N-1:0] : bus.rd2);
  assign cmpDiff = opA[N-1:0] - cmpB;

  always_comb begin
    aluResult = '0;
    if (isCtrl) begin
      aluResult[N-1:0] = bus.pc + bus.imm;
    end else begin
      for (int k = 0; k < M; k++) begin
        if (bus.modeSel || k == 0)
          aluResult[k*N +: N] = aluLane(bus.aluControl, opA[k*N +: N], opB[k*N +: N]);
      end
    end
  end

  assign zeroFlag = isCtrl ? (cmpDiff == '0) : (aluResult == '0);
  assign negFlag  = isCtrl ? cmpDiff[N-1]    : aluResult[N-1];

  assign nextBuffer = {bus.modeSel, bus.opType, bus.opCode, aluResult, zeroFlag, negFlag,
                       bus.branchFlag, bus.memWrite, bus.memToReg, bus.regWrite, bus.Rc,
                       opThird};

  // EX/MEM register boundary
  always_ff @(posedge clk) begin
    if (!rst)
      bufferOut_p1 <= '0;
    else if (bus.en)
      bufferOut_p1 <= nextBuffer;
  end

  assign bus.bufferOut = bufferOut_p1;
endmodule

// File: tb/tb_exec_stage.sv
// Bench for exec_stage: directed vector table, hold/reset sequences, random vs lane model.
module tb_exec_stage;
  localparam int N  = 24;
  localparam int M  = 6;
  localparam int NM = N * M;
  localparam int BW = 17 + 2 * NM;
  localparam longint MODV = 64'd1 << N;

  typedef struct {
    logic [N-1:0]  rd1, rd2, rd3, pc, imm;
    logic [NM-1:0] rdv1, rdv2, rdv3, f1, f2, f3;
    logic fa, fb, fc, immSrc, branchFlag, memWrite, memToReg, regWrite, modeSel;
    logic [1:0] opType;
    logic [3:0] opCode, aluControl, rc;
  } stim_t;

  typedef struct {
    stim_t         s;
    logic [NM-1:0] expAlu;
    logic          expZero;
    logic          expNeg;
    logic [NM-1:0] expRd3;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nCmp = 0;
  int   nBad = 0;

  exec_if #(.N(N), .M(M)) bus();
  exec_stage #(.N(N), .M(M)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic stim_t blank();
    stim_t s;
    s.rd1 = '0; s.rd2 = '0; s.rd3 = '0; s.pc = '0; s.imm = '0;
    s.rdv1 = '0; s.rdv2 = '0; s.rdv3 = '0; s.f1 = '0; s.f2 = '0; s.f3 = '0;
    s.fa = 0; s.fb = 0; s.fc = 0; s.immSrc = 0; s.branchFlag = 0; s.memWrite = 0;
    s.memToReg = 0; s.regWrite = 0; s.modeSel = 0; s.opType = 2'b00;
    s.opCode = '0; s.aluControl = '0; s.rc = '0;
    return s;
  endfunction

  function automatic logic [NM-1:0] randVec();
    logic [NM-1:0] v;
    for (int k = 0; k < M; k++) v[k*N +: N] = N'($urandom);
    return v;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rd1 = N'($urandom); s.rd2 = N'($urandom); s.rd3 = N'($urandom);
    s.pc = N'($urandom); s.imm = N'($urandom);
    s.rdv1 = randVec(); s.rdv2 = randVec(); s.rdv3 = randVec();
    s.f1 = randVec(); s.f2 = randVec(); s.f3 = randVec();
    {s.fa, s.fb, s.fc, s.immSrc, s.branchFlag, s.memWrite, s.memToReg, s.regWrite,
     s.modeSel} = 9'($urandom);
    s.opType = 2'($urandom); s.opCode = 4'($urandom);
    s.aluControl = 4'($urandom); s.rc = 4'($urandom);
    // Small B values exercise the shift range including >= N.
    if ($urandom_range(0, 1) == 1) begin
      s.rd2 = N'($urandom_range(0, 40));
      s.imm = N'($urandom_range(0, 40));
    end
    return s;
  endfunction

  function automatic longint lane(input logic [NM-1:0] v, input int k);
    return longint'(v[k*N +: N]);
  endfunction

  function automatic longint aluRef(input logic [3:0] op, input longint a, input longint b);
    longint sh;
    sh = b % 32;
    case (op)
      4'd0: return (a + b) % MODV;
      4'd1: return (a - b + MODV) % MODV;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return (sh >= N) ? 0 : (a * (64'd1 << sh)) % MODV;
      4'd6: return (sh >= N) ? 0 : a / (64'd1 << sh);
`ifdef EXEC_MUL_EN
      4'd7: return (a * b) % MODV;
`endif
      4'd8: return b;
      4'd9: return a;
      default: return 0;
    endcase
  endfunction

  function automatic logic [BW-1:0] model(input stim_t s);
    longint a[M], b[M], t[M], r[M];
    longint bReg0, diff;
    logic [NM-1:0] res, rd3o;
    logic z, ng;
    bit active;
    for (int k = 0; k < M; k++) begin
      active = s.modeSel || (k == 0);
      a[k] = !active ? 0 : s.fa ? lane(s.f1, k) : (s.modeSel ? lane(s.rdv1, k) : longint'(s.rd1));
      b[k] = !active ? 0 : s.immSrc ? longint'(s.imm) :
             s.fb ? lane(s.f2, k) : (s.modeSel ? lane(s.rdv2, k) : longint'(s.rd2));
      t[k] = !active ? 0 : s.fc ? lane(s.f3, k) : (s.modeSel ? lane(s.rdv3, k) : longint'(s.rd3));
      r[k] = active ? aluRef(s.aluControl, a[k], b[k]) : 0;
    end
    if (s.opType == 2'b10) begin
      for (int k = 0; k < M; k++) r[k] = 0;
      r[0] = (longint'(s.pc) + longint'(s.imm)) % MODV;
      bReg0 = s.fb ? lane(s.f2, 0) : (s.modeSel ? lane(s.rdv2, 0) : longint'(s.rd2));
      diff = (a[0] - bReg0 + MODV) % MODV;
      z  = (diff == 0);
      ng = (diff >= MODV / 2);
    end else begin
      z = 1'b1;
      for (int k = 0; k < M; k++) if (r[k] != 0) z = 1'b0;
      ng = (r[0] >= MODV / 2);
    end
    for (int k = 0; k < M; k++) begin
      res[k*N +: N]  = r[k][N-1:0];
      rd3o[k*N +: N] = t[k][N-1:0];
    end
    return {s.modeSel, s.opType, s.opCode, res, z, ng, s.branchFlag, s.memWrite,
            s.memToReg, s.regWrite, s.rc, rd3o};
  endfunction

  task automatic drive(input stim_t s);
    bus.rd1 = s.rd1; bus.rd2 = s.rd2; bus.rd3 = s.rd3; bus.pc = s.pc; bus.imm = s.imm;
    bus.rdv1 = s.rdv1; bus.rdv2 = s.rdv2; bus.rdv3 = s.rdv3;
    bus.Forward1 = s.f1; bus.Forward2 = s.f2; bus.Forward3 = s.f3;
    bus.Fa = s.fa; bus.Fb = s.fb; bus.Fc = s.fc; bus.immSrc = s.immSrc;
    bus.branchFlag = s.branchFlag; bus.memWrite = s.memWrite; bus.memToReg = s.memToReg;
    bus.regWrite = s.regWrite; bus.modeSel = s.modeSel; bus.opType = s.opType;
    bus.opCode = s.opCode; bus.aluControl = s.aluControl; bus.Rc = s.rc;
  endtask

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t          tbl[9];
  stim_t         s, sAdd;
  logic [BW-1:0] expBuf;

  initial begin
    // Directed vectors
    for (int i = 0; i < 9; i++) begin
      tbl[i].s = blank(); tbl[i].expAlu = '0; tbl[i].expZero = 0;
      tbl[i].expNeg = 0; tbl[i].expRd3 = '0;
    end
    tbl[0].s.modeSel = 1; tbl[0].s.rdv1 = NM'(540); tbl[0].s.rdv2 = NM'(300);
    tbl[0].s.rdv3 = NM'(192);
    tbl[0].expAlu = NM'(840); tbl[0].expRd3 = NM'(192);
    tbl[1].s = tbl[0].s; tbl[1].s.fa = 1; tbl[1].s.fb = 1; tbl[1].s.fc = 1;
    tbl[1].s.f1 = NM'(150); tbl[1].s.f2 = NM'(832); tbl[1].s.f3 = NM'(1022);
    tbl[1].expAlu = NM'(982); tbl[1].expRd3 = NM'(1022);
    tbl[2].s.rd1 = 5; tbl[2].s.rd2 = 7; tbl[2].s.rd3 = 32; tbl[2].s.aluControl = 4'b0001;
    tbl[2].s.rc = 4'hA; tbl[2].s.regWrite = 1;
    tbl[2].expAlu = NM'(24'hFFFFFE); tbl[2].expNeg = 1; tbl[2].expRd3 = NM'(32);
    tbl[3].s.opType = 2'b10; tbl[3].s.pc = 24'h100; tbl[3].s.imm = 24'h20;
    tbl[3].s.rd1 = 9; tbl[3].s.rd2 = 9; tbl[3].s.branchFlag = 1; tbl[3].s.immSrc = 1;
    tbl[3].expAlu = NM'(24'h120); tbl[3].expZero = 1;
    tbl[4].s.rd1 = 3; tbl[4].s.rd2 = 4; tbl[4].s.aluControl = 4'b0111;
`ifdef EXEC_MUL_EN
    tbl[4].expAlu = NM'(12);
`else
    tbl[4].expZero = 1;
`endif
    tbl[5].s.rd1 = 1; tbl[5].s.rd2 = 24; tbl[5].s.aluControl = 4'b0101; tbl[5].expZero = 1;
    tbl[6].s.rd1 = 24'h800000; tbl[6].s.rd2 = 23; tbl[6].s.aluControl = 4'b0110;
    tbl[6].expAlu = NM'(1);
    tbl[7].s.modeSel = 1; tbl[7].s.immSrc = 1; tbl[7].s.imm = 5; tbl[7].s.aluControl = 4'b1000;
    tbl[7].s.rdv3 = {M{24'hABCDEF}};
    tbl[7].expAlu = {M{24'd5}}; tbl[7].expRd3 = {M{24'hABCDEF}};
    tbl[8].s.modeSel = 1; tbl[8].s.rdv1 = {M{24'h123456}}; tbl[8].s.aluControl = 4'b1111;
    tbl[8].s.opType = 2'b11; tbl[8].s.opCode = 4'h9; tbl[8].expZero = 1;

    // Reset with arbitrary inputs, then idle with en low
    rst = 0; bus.en = 1; drive(randStim());
    tick();
    check("reset_clears", bus.bufferOut, '0);
    rst = 1; bus.en = 0;
    tick();
    check("reset_idle_hold", bus.bufferOut, '0);

    for (int i = 0; i < 9; i++) begin
      s = tbl[i].s;
      drive(s); bus.en = 1;
      tick();
      check($sformatf("vec%0d_alu", i), BW'(bus.bufferOut[297:154]), BW'(tbl[i].expAlu));
      check($sformatf("vec%0d_zero", i), BW'(bus.bufferOut[153]), BW'(tbl[i].expZero));
      check($sformatf("vec%0d_neg", i), BW'(bus.bufferOut[152]), BW'(tbl[i].expNeg));
      check($sformatf("vec%0d_rd3", i), BW'(bus.bufferOut[143:0]), BW'(tbl[i].expRd3));
      check($sformatf("vec%0d_ctl", i),
            BW'({bus.bufferOut[304:298], bus.bufferOut[151:144]}),
            BW'({s.modeSel, s.opType, s.opCode, s.branchFlag, s.memWrite, s.memToReg,
                 s.regWrite, s.rc}));
      check($sformatf("vec%0d_model", i), bus.bufferOut, model(s));
    end

    // Hold: load, then stall with changing inputs
    sAdd = tbl[0].s;
    drive(sAdd); bus.en = 1;
    tick();
    bus.en = 0;
    for (int i = 0; i < 3; i++) begin
      drive(randStim());
      tick();
      check("hold_stall", bus.bufferOut, model(sAdd));
    end

    // Reset mid-operation beats en
    drive(tbl[1].s); bus.en = 1; rst = 0;
    tick();
    check("reset_over_en", bus.bufferOut, '0);
    rst = 1;
    tick();
    check("reload_after_reset", bus.bufferOut, model(tbl[1].s));

    // Random stimulus against the lane model
    expBuf = model(tbl[1].s);
    for (int i = 0; i < 400; i++) begin
      s = randStim();
      drive(s);
      bus.en = ($urandom_range(0, 3) != 0);
      if (bus.en) expBuf = model(s);
      tick();
      check($sformatf("rand%0d", i), bus.bufferOut, expBuf);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
